// File: rtl/div_seq_ctrl_if.sv
// Issue/result handshake bundle between the arithmetic issue logic (master)
// and the iterative divide controller (slave).
interface div_seq_ctrl_if #(
  parameter int a_width = 32,
  parameter int b_width = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [a_width-1:0] in_a;
  logic [b_width-1:0] in_b;
  logic               out_valid;
  logic               out_ready;
  logic [a_width-1:0] out_q;
  logic [b_width-1:0] out_r;
  logic               out_dz;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_dz
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_q, out_r, out_dz
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Iterative divide controller: sequences one registered non-restoring stage over
// a_width/num_adders passes. Optional macro DIV_SEQ_EARLY_ZERO_EN short-cuts 0/b.
module div_seq_ctrl #(
  parameter int a_width    = 32,
  parameter int b_width    = 32,
  parameter int num_adders = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  div_seq_ctrl_if.slave      bus,
  output logic               stg_en,
  output logic [a_width-1:0] stg_dividend,
  output logic [b_width-1:0] stg_b,
  output logic [b_width:0]   stg_sum,
  output logic               stg_dz,
  input  logic [a_width-1:0] stg_dividend_r,
  input  logic [b_width:0]   stg_sum_r,
  input  logic               stg_dz_r
);

  localparam int N  = a_width / num_adders;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((a_width % num_adders) != 0) begin : g_bad_cfg
    $error("div_seq_ctrl: num_adders must divide a_width exactly");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [a_width-1:0] a_reg, a_next;
  logic [b_width-1:0] b_reg, b_next;
  logic               dz_reg, dz_next;
  logic [a_width-1:0] q_reg, q_next;
  logic [b_width-1:0] r_reg, r_next;
  logic               dzo_reg, dzo_next;

  logic [b_width-1:0] a_trunc;
  logic [b_width:0]   sum_fix;
  logic [b_width-1:0] r_fix;

  // Divide-by-zero remainder is the dividend, fitted to the remainder width.
  if (b_width > a_width) begin : g_a_ext
    assign a_trunc = {{(b_width - a_width){1'b0}}, a_reg};
  end else begin : g_a_cut
    assign a_trunc = a_reg[b_width-1:0];
  end

  assign sum_fix = stg_sum_r + {1'b0, b_reg};
  assign r_fix   = stg_sum_r[b_width] ? sum_fix[b_width-1:0] : stg_sum_r[b_width-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      dz_reg    <= 1'b0;
      q_reg     <= '0;
      r_reg     <= '0;
      dzo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      dz_reg    <= dz_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      dzo_reg   <= dzo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    dz_next    = dz_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    dzo_next   = dzo_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.in_a;
          b_next     = bus.in_b;
          dz_next    = (bus.in_b == '0);
          cnt_next   = '0;
          state_next = RUN;
`ifdef DIV_SEQ_EARLY_ZERO_EN
          if (bus.in_a == '0 && bus.in_b != '0) begin
            q_next     = '0;
            r_next     = '0;
            dzo_next   = 1'b0;
            state_next = DONE;
          end
`endif
        end
      end
      RUN: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) state_next = FIX;
      end
      FIX: begin
        // Stage holds here, so its registered outputs are the final pass.
        q_next     = stg_dz_r ? '1 : stg_dividend_r;
        r_next     = stg_dz_r ? a_trunc : r_fix;
        dzo_next   = stg_dz_r;
        state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stg_en       = 1'b0;
    stg_dividend = '0;
    stg_b        = '0;
    stg_sum      = '0;
    stg_dz       = 1'b0;
    if (state_reg == RUN) begin
      stg_en = 1'b1;
      stg_b  = b_reg;
      stg_dz = dz_reg;
      if (cnt_reg == '0) begin
        stg_dividend = a_reg;
      end else begin
        stg_dividend = stg_dividend_r;
        stg_sum      = stg_sum_r;
      end
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_q     = q_reg;
  assign bus.out_r     = r_reg;
  assign bus.out_dz    = dzo_reg;

endmodule
